// File: rtl/reg_fifo_reader_pkg.sv
// Shared definitions for the register-based FIFO: default sizing for the
// issue/LSU path instances and a constant clog2 used to size pointers/counts.
package reg_fifo_reader_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_AFULL_TH = 3;

  // Ceiling log2, evaluated at elaboration; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/reg_fifo_reader_if.sv
// Push/pop/status bundle between the FIFO and its producer/consumer.
// master = the side driving pushes and pops, slave = the FIFO itself.
interface reg_fifo_reader_if
  import reg_fifo_reader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);

  localparam int CNT_W = clog2(DEPTH + 1);

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_pop;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             full;
  logic             almost_full;
  logic [CNT_W-1:0] count;
  logic             ovf_err;
  logic             unf_err;
  logic             err_clr;

  modport master (
    output wr_en, wr_data, rd_pop, err_clr,
    input  rd_valid, rd_data, full, almost_full, count, ovf_err, unf_err
  );

  modport slave (
    input  wr_en, wr_data, rd_pop, err_clr,
    output rd_valid, rd_data, full, almost_full, count, ovf_err, unf_err
  );

endinterface

// File: rtl/reg_fifo_reader_ptr.sv
// Circular pointer for the FIFO. Wraps with an explicit compare so DEPTH
// does not have to be a power of two.
module reg_fifo_ptr
  import reg_fifo_reader_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inc,
  output logic [clog2(DEPTH)-1:0] ptr
);

  localparam int PTR_W = clog2(DEPTH);

  // Advance on inc, returning to 0 after the last entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/reg_fifo_reader.sv
// Flip-flop FIFO with first-word-fall-through read side. Absorbs back-pressure
// between a register-write stage and its consumer, with sticky overflow and
// underflow flags for dropped pushes and ignored pops.
module reg_fifo_reader
  import reg_fifo_reader_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AFULL_TH = DEF_AFULL_TH
) (
  input logic               clk,
  input logic               rst,
  reg_fifo_reader_if.slave  bus
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_reg;
  logic             ovf_reg;
  logic             unf_reg;
  logic             empty;
  logic             full_w;
  logic             push_ok;
  logic             pop_ok;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty   = (count_reg == '0);
  assign full_w  = (count_reg == CNT_W'(DEPTH));
  assign pop_ok  = bus.rd_pop & ~empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign push_ok = bus.wr_en & (~full_w | pop_ok);

  reg_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push_ok),
    .ptr (wr_ptr)
  );

  reg_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop_ok),
    .ptr (rd_ptr)
  );

  // One enabled register per entry; contents are intentionally not reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;

      // Capture push data when the write pointer selects this entry.
      always_ff @(posedge clk) begin
        if (push_ok && (wr_ptr == PTR_W'(gi))) begin
          entry_reg <= bus.wr_data;
        end
      end

      assign mem[gi] = entry_reg;
    end
  endgenerate

  // Occupancy tracking and sticky error flags (a new error beats err_clr).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      ovf_reg <= (bus.wr_en & ~push_ok) | (ovf_reg & ~bus.err_clr);
      unf_reg <= (bus.rd_pop & empty)   | (unf_reg & ~bus.err_clr);
    end
  end

  assign bus.rd_valid    = ~empty;
  assign bus.rd_data     = mem[rd_ptr];
  assign bus.full        = full_w;
  assign bus.almost_full = (count_reg >= CNT_W'(AFULL_TH));
  assign bus.count       = count_reg;
  assign bus.ovf_err     = ovf_reg;
  assign bus.unf_err     = unf_reg;

endmodule

// File: tb/tb_reg_fifo_reader.sv
// Bench for reg_fifo_reader: a DEPTH=4 and a DEPTH=3 instance, each shadowed
// by a queue model that is compared against the outputs every cycle.
module tb_reg_fifo_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  reg_fifo_reader_if #(.WIDTH(8), .DEPTH(4)) bus4 ();
  reg_fifo_reader_if #(.WIDTH(8), .DEPTH(3)) bus3 ();

  reg_fifo_reader #(.WIDTH(8), .DEPTH(4), .AFULL_TH(3)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  reg_fifo_reader #(.WIDTH(8), .DEPTH(3), .AFULL_TH(2)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] q4[$];
  logic [7:0] q3[$];
  bit m_ovf4, m_unf4, m_ovf3, m_unf3;
  bit pok4, wok4, pok3, wok3, e4, e3;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q4.delete();
      q3.delete();
      m_ovf4 = 0; m_unf4 = 0; m_ovf3 = 0; m_unf3 = 0;
    end else begin
      e4   = (q4.size() == 0);
      pok4 = bus4.rd_pop && !e4;
      wok4 = bus4.wr_en && ((q4.size() < 4) || pok4);
      m_unf4 = (bus4.rd_pop && e4) || (m_unf4 && !bus4.err_clr);
      m_ovf4 = (bus4.wr_en && !wok4) || (m_ovf4 && !bus4.err_clr);
      if (pok4) begin
        $display("dut4 pop  %02h", q4[0]);
        void'(q4.pop_front());
      end
      if (wok4) begin
        $display("dut4 push %02h", bus4.wr_data);
        q4.push_back(bus4.wr_data);
      end

      e3   = (q3.size() == 0);
      pok3 = bus3.rd_pop && !e3;
      wok3 = bus3.wr_en && ((q3.size() < 3) || pok3);
      m_unf3 = (bus3.rd_pop && e3) || (m_unf3 && !bus3.err_clr);
      m_ovf3 = (bus3.wr_en && !wok3) || (m_ovf3 && !bus3.err_clr);
      if (pok3) begin
        $display("dut3 pop  %02h", q3[0]);
        void'(q3.pop_front());
      end
      if (wok3) begin
        $display("dut3 push %02h", bus3.wr_data);
        q3.push_back(bus3.wr_data);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("valid4", bus4.rd_valid,    q4.size() != 0);
      check("count4", bus4.count,       q4.size());
      check("full4",  bus4.full,        q4.size() == 4);
      check("afull4", bus4.almost_full, q4.size() >= 3);
      check("ovf4",   bus4.ovf_err,     m_ovf4);
      check("unf4",   bus4.unf_err,     m_unf4);
      if (q4.size() != 0) check("data4", bus4.rd_data, q4[0]);

      check("valid3", bus3.rd_valid,    q3.size() != 0);
      check("count3", bus3.count,       q3.size());
      check("full3",  bus3.full,        q3.size() == 3);
      check("afull3", bus3.almost_full, q3.size() >= 2);
      check("ovf3",   bus3.ovf_err,     m_ovf3);
      check("unf3",   bus3.unf_err,     m_unf3);
      if (q3.size() != 0) check("data3", bus3.rd_data, q3[0]);
    end
  end

  // ---------------- stimulus ----------------
  // One clock of activity; returns 2 time units after the edge with inputs idle.
  task automatic cyc4(input bit we, input logic [7:0] d, input bit pop, input bit clr);
    @(negedge clk);
    #1;
    bus4.wr_en = we; bus4.wr_data = d; bus4.rd_pop = pop; bus4.err_clr = clr;
    @(posedge clk);
    #1;
    bus4.wr_en = 0; bus4.rd_pop = 0; bus4.err_clr = 0;
    #1;
  endtask

  task automatic cyc3(input bit we, input logic [7:0] d, input bit pop, input bit clr);
    @(negedge clk);
    #1;
    bus3.wr_en = we; bus3.wr_data = d; bus3.rd_pop = pop; bus3.err_clr = clr;
    @(posedge clk);
    #1;
    bus3.wr_en = 0; bus3.rd_pop = 0; bus3.err_clr = 0;
    #1;
  endtask

  initial begin
    bus4.wr_en = 0; bus4.wr_data = 0; bus4.rd_pop = 0; bus4.err_clr = 0;
    bus3.wr_en = 0; bus3.wr_data = 0; bus3.rd_pop = 0; bus3.err_clr = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", bus4.count, 0);
    check("rst_valid", bus4.rd_valid, 0);
    check("rst_full",  bus4.full, 0);
    check("rst_afull", bus4.almost_full, 0);
    check("rst_ovf",   bus4.ovf_err, 0);
    check("rst_unf",   bus4.unf_err, 0);
    @(negedge clk);
    #2 rst = 0;

    // 1: asynchronous reset mid-operation
    cyc4(1, 8'h01, 0, 0);
    cyc4(1, 8'h02, 0, 0);
    cyc4(1, 8'h03, 0, 0);
    check("t1_pre_count", bus4.count, 3);
    @(negedge clk);
    #2 rst = 1;
    #1;
    check("t1_async_count", bus4.count, 0);
    check("t1_async_valid", bus4.rd_valid, 0);
    @(negedge clk);
    #2 rst = 0;
    cyc4(1, 8'h11, 0, 0);
    check("t1_data", bus4.rd_data, 8'h11);
    check("t1_count", bus4.count, 1);
    cyc4(0, 8'h00, 1, 0);

    // 2: fill to full, then drain in order
    cyc4(1, 8'hA1, 0, 0);
    cyc4(1, 8'hA2, 0, 0);
    check("t2_afull_2", bus4.almost_full, 0);
    cyc4(1, 8'hA3, 0, 0);
    check("t2_afull_3", bus4.almost_full, 1);
    check("t2_full_3",  bus4.full, 0);
    cyc4(1, 8'hA4, 0, 0);
    check("t2_full_4",  bus4.full, 1);
    check("t2_count_4", bus4.count, 4);
    for (int i = 0; i < 4; i++) begin
      check("t2_pop_data", bus4.rd_data, 8'hA1 + i);
      cyc4(0, 8'h00, 1, 0);
    end
    check("t2_empty", bus4.rd_valid, 0);

    // 3: full with simultaneous push/pop across the wrap, then a dropped push
    for (int i = 0; i < 4; i++) cyc4(1, 8'hB0 + 8'(i), 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc4(1, 8'hC0 + 8'(i), 1, 0);
      check("t3_count", bus4.count, 4);
      check("t3_ovf", bus4.ovf_err, 0);
    end
    check("t3_head", bus4.rd_data, 8'hC2);
    cyc4(1, 8'hEE, 0, 0);
    check("t3_ovf_set", bus4.ovf_err, 1);
    for (int i = 0; i < 4; i++) begin
      check("t3_drain", bus4.rd_data, 8'hC2 + i);
      cyc4(0, 8'h00, 1, 0);
    end
    check("t3_empty", bus4.rd_valid, 0);

    // 4: push and pop on an empty FIFO in the same cycle
    cyc4(0, 8'h00, 0, 1);
    check("t4_ovf_clr", bus4.ovf_err, 0);
    cyc4(1, 8'h5C, 1, 0);
    check("t4_unf", bus4.unf_err, 1);
    check("t4_count", bus4.count, 1);
    check("t4_data", bus4.rd_data, 8'h5C);

    // 5: err_clr alone clears; err_clr with a new empty pop keeps it set
    cyc4(0, 8'h00, 0, 1);
    check("t5_clr", bus4.unf_err, 0);
    cyc4(0, 8'h00, 1, 0);
    cyc4(0, 8'h00, 1, 0);
    check("t5_unf_again", bus4.unf_err, 1);
    cyc4(0, 8'h00, 1, 1);
    check("t5_set_wins", bus4.unf_err, 1);
    cyc4(0, 8'h00, 0, 1);
    check("t5_final_clr", bus4.unf_err, 0);

    // 6: DEPTH=3 instance, interleaved random push/pop
    for (int i = 0; i < 3; i++) cyc3(1, 8'h30 + 8'(i), 0, 0);
    check("t6_full3", bus3.full, 1);
    for (int i = 0; i < 40; i++) begin
      cyc3(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    end

    // Extra random traffic on the DEPTH=4 instance
    for (int i = 0; i < 200; i++) begin
      cyc4(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0));
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
